crc_frame_ctrl: RTL and testbench
=================================

Name: crc_frame_ctrl

Overview:
- Sequencer that sits between a byte-oriented requester and the serial 8-bit CRC engine (serial DATA/ACTIVE in, serial CRC/Valid out).
- Accepts a frame of bytes over a valid/ready handshake, resets the engine, and serializes each byte LSB-first with ACTIVE held continuously across the frame.
- Collects the engine's serial CRC into a parallel word and presents it on an output handshake.
- Detects input underrun, engine timeout and short CRC bursts.

Parameters:
DATA_WIDTH, 8, bits per input word shifted into the engine
CRC_WIDTH, 8, engine CRC length in bits (LFSR width)
TIMEOUT, 16, max cycles in WAITV before the engine is declared hung

Ports:
CLK  input  1  clock; all logic on rising edge
RST  input  1  synchronous, active-high reset
IN_DATA  input  DATA_WIDTH  frame word
IN_LAST  input  1  marks final word of frame
IN_VALID  input  1  requester word valid
IN_READY  output  1  controller accepts word when IN_VALID&&IN_READY
OUT_CRC  output  CRC_WIDTH  collected CRC, bit i = i-th serial sample
OUT_VALID  output  1  OUT_CRC valid; held until OUT_READY
OUT_READY  input  1  consumer accepts result
BUSY  output  1  high in every state except IDLE
ERR  output  1  one-cycle error pulse
ERR_CODE  output  2  1=underrun, 2=timeout, 3=short burst; holds until next error or reset
ENG_DATA  output  1  serial bit to engine DATA
ENG_ACTIVE  output  1  to engine ACTIVE
ENG_RST_N  output  1  active-low engine reset
ENG_CRC  input  1  engine serial CRC
ENG_VALID  input  1  engine Valid

Behaviour:
- All outputs registered. RST high: state=IDLE, IN_READY=0, OUT_CRC=0, OUT_VALID=0, BUSY=0, ERR=0, ERR_CODE=0, ENG_DATA=0, ENG_ACTIVE=0, ENG_RST_N=0. First cycle after RST: ENG_RST_N=1, IN_READY=1.
- States: IDLE, RSTE, SHIFT, WAITV, COLLECT, DONE.
- IDLE: IN_READY=1. On handshake, latch word and last flag into the current register. Next state RSTE.
- RSTE: exactly 1 cycle, ENG_RST_N=0, ENG_ACTIVE=0. Next state SHIFT.
- SHIFT:
  - ENG_ACTIVE=1; ENG_DATA=cur[bit], bit counter 0..DATA_WIDTH-1.
  - The first bit appears 2 cycles after the IDLE handshake.
  - One-word prefetch buffer: IN_READY=1 while the buffer is empty and the current word is not last.
  - At bit DATA_WIDTH-1:
    - current word is last: next state WAITV, ENG_ACTIVE=0 in the following cycle.
    - buffer full: move buffer to current, counter=0; ENG_ACTIVE stays 1 with no gap.
    - buffer empty: underrun. ERR=1, ERR_CODE=1, ENG_ACTIVE=0, ENG_RST_N=0 for 1 cycle, then IDLE. No OUT_VALID.
  - A handshake and a buffer drain in the same cycle are legal; the new word lands in the buffer.
- WAITV:
  - Timeout counter starts at 0 on entry.
  - ENG_VALID=1 at an edge: capture ENG_CRC as bit 0, next state COLLECT.
  - Counter reaches TIMEOUT with no ENG_VALID: ERR, ERR_CODE=2, engine reset pulse, IDLE.
- COLLECT:
  - On each edge with ENG_VALID=1, capture ENG_CRC into the next bit position, LSB first.
  - After CRC_WIDTH bits: next state DONE.
  - ENG_VALID=0 before all bits are captured: ERR, ERR_CODE=3, engine reset pulse, IDLE.
- DONE: OUT_VALID=1, OUT_CRC stable. On OUT_READY, clear OUT_VALID and go to IDLE. IN_READY=0 while in DONE.
- Cycle count, N-word frame with no stalls: IDLE handshake to first WAITV cycle = 1 + N·DATA_WIDTH + 1 cycles. Best-case result appears 1 cycle after the last CRC sample.
- IN_VALID is ignored outside IDLE and buffer-empty SHIFT. IN_DATA is sampled only on handshake.
- RST asserted mid-frame: immediate return to reset values, partial CRC discarded, no ERR pulse.

Test Plan:
- Bench uses an engine model that answers any frame with CRC 8'hA5, serial LSB first.
- Single word 8'h3C, IN_LAST=1 -> ENG_RST_N low 1 cycle; ENG_DATA sequence 0,0,1,1,1,1,0,0 with ENG_ACTIVE high exactly 8 cycles; OUT_CRC=8'hA5, OUT_VALID held until OUT_READY.
- Three-word frame 8'h01, 8'h80, 8'hFF, all offered in time -> ENG_ACTIVE continuous for 24 cycles; IN_READY pulses for prefetch; OUT_CRC=8'hA5; ERR never asserted.
- Two-word frame, second word withheld until after first word's bit 7 -> ERR pulse, ERR_CODE=1, ENG_RST_N low 1 cycle, return to IDLE, OUT_VALID=0.
- Engine model never raises Valid -> ERR after 16 WAITV cycles, ERR_CODE=2.
- Engine model drops Valid after 5 bits -> ERR_CODE=3.
- Assert RST during SHIFT bit 4 -> all outputs at reset values next cycle; following frame 8'h3C completes normally with OUT_CRC=8'hA5.
- Hold OUT_READY=0 for 10 cycles in DONE -> OUT_VALID and OUT_CRC stable throughout, IN_READY=0.

Source files
------------

// File: rtl/crc_frame_ctrl.sv
// crc_frame_ctrl: feeds byte frames LSB-first into a serial CRC engine,
// gathers the serial CRC back into a word and reports underrun, engine
// timeout and short CRC bursts.
module crc_frame_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int CRC_WIDTH  = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] IN_DATA,
   input  logic                  IN_LAST,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   output logic [CRC_WIDTH-1:0]  OUT_CRC,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic                  BUSY,
   output logic                  ERR,
   output logic [1:0]            ERR_CODE,
   output logic                  ENG_DATA,
   output logic                  ENG_ACTIVE,
   output logic                  ENG_RST_N,
   input  logic                  ENG_CRC,
   input  logic                  ENG_VALID
);

   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int CW = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
   localparam logic [CW-1:0] CRC_LAST  = CW'(CRC_WIDTH - 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] E_UNDERRUN = 2'd1;
   localparam logic [1:0] E_TIMEOUT  = 2'd2;
   localparam logic [1:0] E_SHORT    = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE, S_RSTE, S_SHIFT, S_WAITV, S_COLLECT, S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] cur_q, cur_d, buf_q, buf_d;
   logic                  cur_last_q, cur_last_d, buf_last_q, buf_last_d;
   logic                  buf_full_q, buf_full_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [TW-1:0]         wait_q, wait_d;
   logic [CW-1:0]         col_q, col_d;
   logic [CRC_WIDTH-1:0]  crc_q, crc_d, crc_shift, out_crc_d;
   logic                  err_d;
   logic [1:0]            err_code_d;
   logic                  in_ready_d, hs;

   // First serial sample enters at the top and ends up in bit 0.
   assign crc_shift = {ENG_CRC, crc_q[CRC_WIDTH-1:1]};
   assign hs        = IN_VALID && IN_READY;

   // Next-state and next-output logic; registered outputs follow the next state.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      cur_d      = cur_q;
      cur_last_d = cur_last_q;
      buf_d      = buf_q;
      buf_last_d = buf_last_q;
      buf_full_d = buf_full_q;
      bit_d      = bit_q;
      wait_d     = wait_q;
      col_d      = col_q;
      crc_d      = crc_q;
      out_crc_d  = OUT_CRC;
      err_d      = 1'b0;
      err_code_d = ERR_CODE;

      case (state_q)
         S_IDLE: begin
            if (hs) begin
               cur_d      = IN_DATA;
               cur_last_d = IN_LAST;
               buf_full_d = 1'b0;
               bit_d      = '0;
               state_d    = S_RSTE;
            end
         end
         S_RSTE: state_d = S_SHIFT;
         S_SHIFT: begin
            if (bit_q == BIT_LAST) begin
               if (cur_last_q) begin
                  wait_d  = '0;
                  state_d = S_WAITV;
               end else if (buf_full_q) begin
                  // Drain the prefetch buffer; a same-cycle handshake refills it.
                  cur_d      = buf_q;
                  cur_last_d = buf_last_q;
                  bit_d      = '0;
                  buf_full_d = hs;
                  if (hs) begin
                     buf_d      = IN_DATA;
                     buf_last_d = IN_LAST;
                  end
               end else if (hs) begin
                  // Word arrived exactly on time: go straight into the shifter.
                  cur_d      = IN_DATA;
                  cur_last_d = IN_LAST;
                  bit_d      = '0;
               end else begin
                  err_d      = 1'b1;
                  err_code_d = E_UNDERRUN;
                  state_d    = S_IDLE;
               end
            end else begin
               bit_d = bit_q + 1'b1;
               if (hs) begin
                  buf_d      = IN_DATA;
                  buf_last_d = IN_LAST;
                  buf_full_d = 1'b1;
               end
            end
         end
         S_WAITV: begin
            if (ENG_VALID) begin
               crc_d   = crc_shift;
               col_d   = CW'(1);
               state_d = S_COLLECT;
            end else if (wait_q == WAIT_LAST) begin
               err_d      = 1'b1;
               err_code_d = E_TIMEOUT;
               state_d    = S_IDLE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_COLLECT: begin
            if (ENG_VALID) begin
               crc_d = crc_shift;
               if (col_q == CRC_LAST) begin
                  out_crc_d = crc_shift;
                  state_d   = S_DONE;
               end else begin
                  col_d = col_q + 1'b1;
               end
            end else begin
               err_d      = 1'b1;
               err_code_d = E_SHORT;
               state_d    = S_IDLE;
            end
         end
         S_DONE: if (OUT_READY) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Ready in IDLE (not during an error pulse) or in SHIFT while the buffer
      // is empty or about to drain, as long as no word marked last is pending.
      in_ready_d = (state_d == S_IDLE && !err_d) ||
                   (state_d == S_SHIFT && !cur_last_d &&
                    (!buf_full_d || (bit_d == BIT_LAST && !buf_last_d)));
   end

   // Control state and all ports; synchronous reset returns everything to idle.
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (RST) begin
         state_q    <= S_IDLE;
         cur_last_q <= 1'b0;
         buf_full_q <= 1'b0;
         bit_q      <= '0;
         wait_q     <= '0;
         col_q      <= '0;
         IN_READY   <= 1'b0;
         OUT_CRC    <= '0;
         OUT_VALID  <= 1'b0;
         BUSY       <= 1'b0;
         ERR        <= 1'b0;
         ERR_CODE   <= 2'd0;
         ENG_DATA   <= 1'b0;
         ENG_ACTIVE <= 1'b0;
         ENG_RST_N  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cur_last_q <= cur_last_d;
         buf_full_q <= buf_full_d;
         bit_q      <= bit_d;
         wait_q     <= wait_d;
         col_q      <= col_d;
         IN_READY   <= in_ready_d;
         OUT_CRC    <= out_crc_d;
         OUT_VALID  <= (state_d == S_DONE);
         BUSY       <= (state_d != S_IDLE);
         ERR        <= err_d;
         ERR_CODE   <= err_code_d;
         ENG_DATA   <= (state_d == S_SHIFT) ? cur_d[bit_d] : 1'b0;
         ENG_ACTIVE <= (state_d == S_SHIFT);
         ENG_RST_N  <= !(state_d == S_RSTE || err_d);
      end
   end

   // Payload registers; their contents only matter while the flags above mark them live.
   always_ff @(posedge CLK) begin
      // NOTE: data-only registers are left out of reset; valid/full flags qualify every use.
      cur_q      <= cur_d;
      buf_q      <= buf_d;
      buf_last_q <= buf_last_d;
      crc_q      <= crc_d;
   end

endmodule

// File: tb/tb_crc_frame_ctrl.sv
// tb_crc_frame_ctrl: directed checks of crc_frame_ctrl against a serial
// engine model that answers every frame with CRC 8'hA5, LSB first.
module tb_crc_frame_ctrl;

   logic       CLK_tb = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in_data = '0;
   logic       in_last = 1'b0, in_valid = 1'b0, in_ready;
   logic [7:0] out_crc;
   logic       out_valid, out_ready = 1'b0, busy, err;
   logic [1:0] err_code;
   logic       eng_data, eng_active, eng_rst_n;
   logic       eng_crc = 1'b0, eng_valid = 1'b0;

   always #5 CLK_tb = ~CLK_tb;

   crc_frame_ctrl #(.DATA_WIDTH(8), .CRC_WIDTH(8), .TIMEOUT(16)) dut (
      .CLK(CLK_tb), .RST(rst),
      .IN_DATA(in_data), .IN_LAST(in_last), .IN_VALID(in_valid), .IN_READY(in_ready),
      .OUT_CRC(out_crc), .OUT_VALID(out_valid), .OUT_READY(out_ready),
      .BUSY(busy), .ERR(err), .ERR_CODE(err_code),
      .ENG_DATA(eng_data), .ENG_ACTIVE(eng_active), .ENG_RST_N(eng_rst_n),
      .ENG_CRC(eng_crc), .ENG_VALID(eng_valid)
   );

   int n_checks = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Engine model: 0 = never answers, 1 = full 8-bit CRC, 2 = drops Valid after 5 bits.
   int         eng_mode = 1;
   logic [7:0] eng_word = 8'hA5;
   logic       eng_prev = 1'b0;

   initial begin
      forever begin
         @(posedge CLK_tb); #1;
         if (eng_prev && !eng_active && eng_rst_n && !rst && eng_mode != 0) begin
            @(posedge CLK_tb); #1;
            for (int i = 0; i < 8; i++) begin
               if (eng_mode == 2 && i == 5) break;
               eng_valid = 1'b1;
               eng_crc   = eng_word[i];
               @(posedge CLK_tb); #1;
            end
            eng_valid = 1'b0;
            eng_crc   = 1'b0;
         end
         eng_prev = eng_active;
      end
   end

   // Per-cycle monitor state, all owned by the stimulus thread.
   int          cyc = 0, act_cycles, act_runs, rstn_low, err_cnt, ov_cnt, ir_rise, hs_cnt;
   int          hs_cyc, first_act_cyc, fall_cyc, err_cyc;
   logic [31:0] data_v;
   logic        prev_act = 1'b0, prev_ir = 1'b0, hs_pend = 1'b0;
   logic [8:0]  wq[$];
   int          bad;

   task automatic mon_clr();
      act_cycles = 0; act_runs = 0; rstn_low = 0; err_cnt = 0; ov_cnt = 0;
      ir_rise = 0; hs_cnt = 0; hs_cyc = -1; first_act_cyc = -1;
      fall_cyc = -1; err_cyc = -1; data_v = '0;
   endtask

   // Advance to the next falling edge, log what the DUT shows, then drive inputs.
   task automatic cycle();
      @(negedge CLK_tb);
      cyc++;
      if (hs_pend) begin
         if (hs_cnt == 0) hs_cyc = cyc - 1;
         hs_cnt++;
         void'(wq.pop_front());
      end
      if (eng_active) begin
         if (act_cycles < 32) data_v[act_cycles] = eng_data;
         act_cycles++;
         if (!prev_act) begin
            if (act_runs == 0) first_act_cyc = cyc;
            act_runs++;
         end
      end
      if (prev_act && !eng_active) fall_cyc = cyc;
      if (!eng_rst_n) rstn_low++;
      if (err) begin err_cnt++; err_cyc = cyc; end
      if (out_valid) ov_cnt++;
      if (busy && in_ready && !prev_ir) ir_rise++;
      prev_act = eng_active;
      prev_ir  = in_ready;
      in_valid = (wq.size() > 0) && !rst;
      if (in_valid) begin
         in_data = wq[0][7:0];
         in_last = wq[0][8];
      end
      hs_pend = in_valid && in_ready;
   endtask

   task automatic wait_done(input string tag);
      for (int i = 0; i < 120 && !out_valid; i++) cycle();
      check(tag, out_valid, 1);
   endtask

   task automatic wait_err(input string tag);
      for (int i = 0; i < 120 && !err; i++) cycle();
      check(tag, err, 1);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      cycle();
      out_ready = 1'b0;
      check("release_ov", out_valid, 0);
      check("release_busy", busy, 0);
      cycle();
   endtask

   initial begin
      mon_clr();
      // Reset values while RST is held.
      repeat (2) cycle();
      check("rst_outs", {in_ready, out_crc, out_valid, busy, err, err_code,
                         eng_data, eng_active, eng_rst_n}, 0);
      rst = 1'b0;
      cycle();
      check("post_rst", {eng_rst_n, in_ready, busy}, 3'b110);

      // Single word 8'h3C, then hold the result for 10 cycles.
      mon_clr();
      wq.push_back({1'b1, 8'h3C});
      wait_done("w1_done");
      check("w1_bits", data_v, 32'h3C);
      check("w1_act_cycles", act_cycles, 8);
      check("w1_act_runs", act_runs, 1);
      check("w1_rstn_low", rstn_low, 1);
      check("w1_first_bit_lat", first_act_cyc - hs_cyc, 2);
      check("w1_waitv_lat", fall_cyc - hs_cyc, 10);
      check("w1_crc", out_crc, 8'hA5);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (!out_valid || out_crc !== 8'hA5 || in_ready) bad++;
      end
      check("done_hold_bad", bad, 0);
      release_result();

      // Three-word frame with prefetch, all words offered up front.
      mon_clr();
      wq.push_back({1'b0, 8'h01});
      wq.push_back({1'b0, 8'h80});
      wq.push_back({1'b1, 8'hFF});
      wait_done("w3_done");
      check("w3_bits", data_v, 32'h00FF8001);
      check("w3_act_cycles", act_cycles, 24);
      check("w3_act_runs", act_runs, 1);
      check("w3_hs", hs_cnt, 3);
      check("w3_ir_pulses", ir_rise, 2);
      check("w3_waitv_lat", fall_cyc - hs_cyc, 26);
      check("w3_err", err_cnt, 0);
      check("w3_crc", out_crc, 8'hA5);
      release_result();

      // Underrun: first word not last, second word withheld.
      mon_clr();
      wq.push_back({1'b0, 8'h5A});
      wait_err("ur_err_seen");
      check("ur_code", err_code, 1);
      check("ur_eng_active", eng_active, 0);
      repeat (3) cycle();
      check("ur_err_pulses", err_cnt, 1);
      check("ur_rstn_low", rstn_low, 2);
      check("ur_act_cycles", act_cycles, 8);
      check("ur_ov", ov_cnt, 0);
      check("ur_idle", {busy, in_ready}, 2'b01);

      // Engine timeout: Valid never rises.
      mon_clr();
      eng_mode = 0;
      wq.push_back({1'b1, 8'h77});
      wait_err("to_err_seen");
      check("to_code", err_code, 2);
      check("to_waitv_cycles", err_cyc - fall_cyc, 16);
      repeat (2) cycle();
      check("to_rstn_low", rstn_low, 2);
      check("to_ov", ov_cnt, 0);
      check("to_busy", busy, 0);

      // Short burst: Valid drops after 5 bits.
      mon_clr();
      eng_mode = 2;
      wq.push_back({1'b1, 8'h3C});
      wait_err("sb_err_seen");
      check("sb_code", err_code, 3);
      repeat (2) cycle();
      check("sb_err_pulses", err_cnt, 1);
      check("sb_ov", ov_cnt, 0);

      // Reset during SHIFT bit 4, then a clean frame.
      mon_clr();
      eng_mode = 1;
      wq.push_back({1'b1, 8'h3C});
      for (int i = 0; i < 40 && act_cycles < 5; i++) cycle();
      check("mr_bit4_reached", act_cycles, 5);
      rst = 1'b1;
      cycle();
      check("mr_rst_outs", {in_ready, out_crc, out_valid, busy, err, err_code,
                            eng_data, eng_active, eng_rst_n}, 0);
      rst = 1'b0;
      cycle();
      check("mr_post_rst", {eng_rst_n, in_ready, busy}, 3'b110);
      mon_clr();
      wq.push_back({1'b1, 8'h3C});
      wait_done("mr_done");
      check("mr_crc", out_crc, 8'hA5);
      check("mr_bits", data_v, 32'h3C);
      check("mr_err", err_cnt, 0);
      release_result();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
